fir_product_accumulator: RTL and testbench
==========================================

FIR_PRODUCT_ACCUMULATOR -- requirements
Module: fir_product_accumulator

Interface
REQ-001 SHALL have parameter NTAPS, default 16: number of products summed per output sample, minimum 2.
REQ-002 SHALL have parameter PROD_W, default 24: signed product width, matching the 16s x 8s multiplier output.
REQ-003 SHALL have parameter ACC_W, default 32: signed accumulator width, at least PROD_W+clog2(NTAPS).
REQ-004 SHALL have parameter OUT_W, default 16: signed output sample width.
REQ-005 SHALL have parameter FRAC_SHIFT, default 7: right shift applied to the sum, for Q1.7 coefficients; minimum 1.
REQ-006 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port prod_tdata, input, PROD_W bits: signed product from the multiplier stage.
REQ-009 SHALL have port prod_tvalid, input, 1 bit: prod_tdata is valid this cycle.
REQ-010 SHALL have port prod_tready, output, 1 bit: the block accepts a product this cycle.
REQ-011 SHALL have port out_tdata, output, OUT_W bits: filtered, rounded sample.
REQ-012 SHALL have port out_tvalid, output, 1 bit: out_tdata is valid.
REQ-013 SHALL have port out_tready, input, 1 bit: the downstream consumer accepts out_tdata.
REQ-014 SHALL have port ovf, output, 1 bit: the current output was saturated.

Function
REQ-015 SHALL implement two states: ACCUM and HOLD.
REQ-016 In ACCUM, prod_tready SHALL be 1; in HOLD, prod_tready SHALL be 0.
REQ-017 A product SHALL be accepted only when prod_tvalid and prod_tready are both 1; gaps in prod_tvalid SHALL not affect the result.
REQ-018 On each accepted product, the tap counter SHALL increment and acc SHALL become acc plus the sign-extended product.
REQ-019 When the product with counter equal to NTAPS-1 is accepted, the block SHALL do all of the following on that edge:
- form sum = acc + product;
- register the output from that sum;
- clear acc and the counter;
- enter HOLD.
REQ-020 out_tvalid SHALL be 1 exactly while in HOLD, starting on the cycle after the last product is accepted (latency 1).
REQ-021 The registered output SHALL be (sum + 2^(FRAC_SHIFT-1)) arithmetic-shifted right by FRAC_SHIFT, which rounds half up.
REQ-022 out_tdata and ovf SHALL hold stable while out_tvalid=1 and out_tready=0.
REQ-023 In HOLD, out_tready=1 SHALL return the block to ACCUM on the next edge; peak throughput is one output per NTAPS+1 cycles.
REQ-024 Accumulation SHALL be two's-complement in ACC_W bits, with no intermediate saturation.

Reset
REQ-025 ap_rst_n=0 SHALL immediately force all of the following: state ACCUM, counter 0, acc 0, out_tdata 0, out_tvalid 0, ovf 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial sum; the first NTAPS products after release SHALL form a fresh frame.

Configuration
REQ-027 With FIR_ACC_SAT_EN defined, a rounded value outside the OUT_W signed range SHALL clamp to the nearest of -2^(OUT_W-1) or 2^(OUT_W-1)-1, and ovf SHALL be set for that output.
REQ-028 Without FIR_ACC_SAT_EN, out_tdata SHALL be the low OUT_W bits of the rounded value (wrap), and ovf SHALL be constant 0.

Structure
REQ-029 A shared package SHALL hold the following, reused by neighbouring filterbank stages:
- the state enum (ACCUM, HOLD);
- the default width constants (PROD_W, ACC_W, OUT_W, FRAC_SHIFT);
- a round-and-saturate function.
REQ-030 The round/saturate/wrap logic SHALL be one combinational sub-module, fir_round_sat; the state machine, counter and accumulator stay in the top module.

Verification (NTAPS=4, FRAC_SHIFT=7)
REQ-031 Products 128,128,128,128 -> out_tdata=4, ovf=0, with out_tvalid rising 1 cycle after the 4th accept.
REQ-032 Rounding SHALL be checked with three frames:
- frame {64,0,0,0} -> 1;
- frame {-64,0,0,0} -> 0;
- frame {-65,0,0,0} -> -1.
REQ-033 Products 4 x 8388607 -> with the macro: 32767, ovf=1; without it: 0x0000, ovf=0; 4 x -8388608 with the macro -> -32768, ovf=1.
REQ-034 Hold out_tready=0 for 5 cycles after a valid output -> out_tdata stable, prod_tready=0, and no products are lost; the next frame's sum is correct.
REQ-035 Accept 2 of 4 products, pulse ap_rst_n low, then send {256,256,0,0} -> out_tdata=4.
REQ-036 Randomly toggle prod_tvalid with back-to-back frames -> outputs match a reference model; no accept occurs in HOLD.

Source files
------------

// File: rtl/fir_product_accumulator_pkg.sv
// Shared definitions for the filterbank product-accumulation stages.
// The state enum, default width constants and the round/saturate helper live here.
// The helper's saturation behaviour is selected by its caller; the FIR_ACC_SAT_EN
// macro is interpreted in fir_round_sat.
package fir_product_accumulator_pkg;

    // Two-state frame controller: collecting products, or presenting a result
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } fir_state_e;

    localparam int FIR_DEF_NTAPS      = 16;
    localparam int FIR_DEF_PROD_W     = 24;
    localparam int FIR_DEF_ACC_W      = 32;
    localparam int FIR_DEF_OUT_W      = 16;
    localparam int FIR_DEF_FRAC_SHIFT = 7;

    // Result of rounding: full-width value plus a flag that clamping occurred
    typedef struct packed {
        logic [63:0] value;
        logic        ovf;
    } fir_round_t;

    // Round half up by adding 2^(frac_shift-1) and shifting arithmetically.
    // When sat_en is set the value is clamped to the out_w signed range and
    // ovf reports the clamp; otherwise the value is returned unclamped and the
    // caller keeps the low out_w bits (wrap).
    function automatic fir_round_t fir_round_sat_f(
        input logic signed [63:0] sum,
        input int                 frac_shift,
        input int                 out_w,
        input logic               sat_en
    );
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        fir_round_t         res;
        rounded   = (sum + (64'sd1 <<< (frac_shift - 1))) >>> frac_shift;
        max_v     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (out_w - 1));
        res.value = rounded;
        res.ovf   = 1'b0;
        if (sat_en && (rounded > max_v)) begin
            res.value = max_v;
            res.ovf   = 1'b1;
        end else if (sat_en && (rounded < min_v)) begin
            res.value = min_v;
            res.ovf   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round/scale stage: turns a full accumulator sum into an
// OUT_W-bit sample. Define FIR_ACC_SAT_EN to clamp out-of-range values and
// raise ovf; without it the low OUT_W bits are kept and ovf stays 0.
module fir_round_sat
    import fir_product_accumulator_pkg::*;
#(
    parameter int ACC_W      = FIR_DEF_ACC_W,
    parameter int OUT_W      = FIR_DEF_OUT_W,
    parameter int FRAC_SHIFT = FIR_DEF_FRAC_SHIFT
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic        [OUT_W-1:0] data_o,
    output logic                    ovf_o
);

`ifdef FIR_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic signed [63:0] sum_ext;
    fir_round_t         res;

    // Sign-extend the sum, round, then clamp or wrap into the output width
    always_comb begin
        sum_ext = {{(64-ACC_W){sum_i[ACC_W-1]}}, sum_i};
        res     = fir_round_sat_f(sum_ext, FRAC_SHIFT, OUT_W, SAT_EN);
        data_o  = OUT_W'(res.value);
        ovf_o   = SAT_EN & res.ovf;
    end

endmodule

// File: rtl/fir_product_accumulator.sv
// Sums NTAPS signed products per output sample, rounds the sum via
// fir_round_sat and holds the result until the consumer takes it.
// Saturating output is enabled by defining FIR_ACC_SAT_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. prod_tready depends only on state (1 in ACCUM); out_tvalid is 1
// exactly in HOLD and out_tdata/ovf do not change while out_tvalid=1 and
// out_tready=0. Gaps in prod_tvalid simply stall the frame.
module fir_product_accumulator
    import fir_product_accumulator_pkg::*;
#(
    parameter int NTAPS      = FIR_DEF_NTAPS,
    parameter int PROD_W     = FIR_DEF_PROD_W,
    parameter int ACC_W      = FIR_DEF_ACC_W,
    parameter int OUT_W      = FIR_DEF_OUT_W,
    parameter int FRAC_SHIFT = FIR_DEF_FRAC_SHIFT
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] prod_tdata,
    input  logic              prod_tvalid,
    output logic              prod_tready,
    output logic [OUT_W-1:0]  out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              ovf,
    output fir_state_e        dbg_state
);

    localparam int                CNT_W    = $clog2(NTAPS);
    localparam logic [CNT_W-1:0]  LAST_TAP = CNT_W'(NTAPS - 1);

    fir_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     ovf_q, ovf_d;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]         rs_data;
    logic                     rs_ovf;
    logic                     prod_accept;

    // Running sum including the product currently offered
    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){prod_tdata[PROD_W-1]}}, prod_tdata};
        sum      = acc_q + prod_ext;
    end

    fir_round_sat #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .sum_i  (sum),
        .data_o (rs_data),
        .ovf_o  (rs_ovf)
    );

    // Next-state: accumulate in ACCUM, capture result on the last tap, release on out_tready
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        prod_accept = prod_tvalid && (state_q == ACCUM);
        case (state_q)
            ACCUM: begin
                if (prod_accept) begin
                    if (cnt_q == LAST_TAP) begin
                        acc_d      = '0;
                        cnt_d      = '0;
                        out_data_d = rs_data;
                        ovf_d      = rs_ovf;
                        state_d    = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_tready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, counter, accumulator and output registers; reset discards any partial frame
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign prod_tready = (state_q == ACCUM);
    assign out_tvalid  = (state_q == HOLD);
    assign out_tdata   = out_data_q;
    assign ovf         = ovf_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fir_product_accumulator.sv
// Bench for fir_product_accumulator with NTAPS=4, FRAC_SHIFT=7.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fir_product_accumulator;
    import fir_product_accumulator_pkg::*;

    localparam int NTAPS      = 4;
    localparam int PROD_W     = 24;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 16;
    localparam int FRAC_SHIFT = 7;
    localparam int EXP_W      = OUT_W + 1;
    localparam int BUDGET     = 200;

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              rst_n;
    logic [PROD_W-1:0] prod_tdata;
    logic              prod_tvalid;
    logic              prod_tready;
    logic [OUT_W-1:0]  out_tdata;
    logic              out_tvalid;
    logic              out_tready;
    logic              ovf;
    fir_state_e        dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_product_accumulator #(
        .NTAPS      (NTAPS),
        .PROD_W     (PROD_W),
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) dut (
        .ap_clk      (clk),
        .ap_rst_n    (rst_n),
        .prod_tdata  (prod_tdata),
        .prod_tvalid (prod_tvalid),
        .prod_tready (prod_tready),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .ovf         (ovf),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: round half up of sum / 2^FRAC_SHIFT, then clamp or wrap
    function automatic logic [EXP_W-1:0] ref_out(input longint sum);
        longint scale, x, q, max_v, min_v;
        logic   o;
        logic [OUT_W-1:0] d;
        scale = longint'(1) << FRAC_SHIFT;
        x     = sum + scale / 2;
        if (x >= 0) q = x / scale;
        else        q = -((-x + scale - 1) / scale);
        max_v = (longint'(1) << (OUT_W - 1)) - 1;
        min_v = -(longint'(1) << (OUT_W - 1));
        o = 1'b0;
`ifdef FIR_ACC_SAT_EN
        if (q > max_v) begin
            q = max_v;
            o = 1'b1;
        end else if (q < min_v) begin
            q = min_v;
            o = 1'b1;
        end
`endif
        d = q[OUT_W-1:0];
        return {o, d};
    endfunction

    // Check that nothing is accepted while a result is being held
    always @(negedge clk) begin
        if (mon_en) chk("no_accept_in_hold", {63'd0, prod_tvalid & prod_tready & out_tvalid}, 64'd0);
    end

    // ---------------- driver tasks ----------------
    task automatic send_prod(input logic signed [PROD_W-1:0] p, input int gap);
        int n;
        prod_tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        prod_tvalid = 1'b1;
        prod_tdata  = p;
        n = 0;
        while (prod_tready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("prod_accept_wait", {63'd0, n < BUDGET}, 64'd1);
        @(negedge clk);
        prod_tvalid = 1'b0;
    endtask

    task automatic push_exp(input int p0, input int p1, input int p2, input int p3);
        longint s;
        s = longint'(p0) + longint'(p1) + longint'(p2) + longint'(p3);
        exp_q.push_back(ref_out(s));
    endtask

    task automatic send_frame(input int p0, input int p1, input int p2, input int p3, input int max_gap);
        push_exp(p0, p1, p2, p3);
        send_prod(PROD_W'(p0), $urandom_range(0, max_gap));
        send_prod(PROD_W'(p1), $urandom_range(0, max_gap));
        send_prod(PROD_W'(p2), $urandom_range(0, max_gap));
        send_prod(PROD_W'(p3), $urandom_range(0, max_gap));
    endtask

    task automatic recv_check(input int stall, output logic [OUT_W-1:0] got_d, output logic got_o);
        logic [EXP_W-1:0] e;
        int n;
        out_tready = 1'b0;
        n = 0;
        while (out_tvalid !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", {63'd0, n < BUDGET}, 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        got_d = out_tdata;
        got_o = ovf;
        chk("out_tdata", {48'd0, out_tdata}, {48'd0, e[OUT_W-1:0]});
        chk("ovf", {63'd0, ovf}, {63'd0, e[OUT_W]});
        repeat (stall) begin
            @(negedge clk);
            chk("stall_tdata", {48'd0, out_tdata}, {48'd0, got_d});
            chk("stall_ovf", {63'd0, ovf}, {63'd0, got_o});
            chk("stall_prod_tready", {63'd0, prod_tready}, 64'd0);
        end
        out_tready = 1'b1;
        @(negedge clk);
        out_tready = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [OUT_W-1:0] d;
        logic o;
        logic signed [PROD_W-1:0] r [4];
        int mode;

        rst_n       = 1'b0;
        prod_tvalid = 1'b0;
        prod_tdata  = '0;
        out_tready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_out_tvalid", {63'd0, out_tvalid}, 64'd0);
        chk("rst_out_tdata", {48'd0, out_tdata}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_prod_tready", {63'd0, prod_tready}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame and latency of one cycle
        push_exp(128, 128, 128, 128);
        send_prod(24'sd128, 0);
        send_prod(24'sd128, 1);
        send_prod(24'sd128, 0);
        chk("pre_last_out_tvalid", {63'd0, out_tvalid}, 64'd0);
        send_prod(24'sd128, 0);
        chk("latency_out_tvalid", {63'd0, out_tvalid}, 64'd1);
        recv_check(0, d, o);
        chk("frame_128", {48'd0, d}, 64'd4);
        chk("frame_128_ovf", {63'd0, o}, 64'd0);

        // Rounding half up
        send_frame(64, 0, 0, 0, 1);
        recv_check(0, d, o);
        chk("round_pos_half", {48'd0, d}, 64'd1);
        send_frame(-64, 0, 0, 0, 1);
        recv_check(0, d, o);
        chk("round_neg_half", {48'd0, d}, 64'd0);
        send_frame(-65, 0, 0, 0, 1);
        recv_check(0, d, o);
        chk("round_neg_below", {48'd0, d}, 64'h0000_0000_0000_FFFF);

        // Out-of-range sums
        send_frame(8388607, 8388607, 8388607, 8388607, 0);
        recv_check(0, d, o);
`ifdef FIR_ACC_SAT_EN
        chk("sat_pos", {48'd0, d}, 64'h7FFF);
        chk("sat_pos_ovf", {63'd0, o}, 64'd1);
`else
        chk("wrap_pos", {48'd0, d}, 64'h0000);
        chk("wrap_pos_ovf", {63'd0, o}, 64'd0);
`endif
        send_frame(-8388608, -8388608, -8388608, -8388608, 0);
        recv_check(0, d, o);
`ifdef FIR_ACC_SAT_EN
        chk("sat_neg", {48'd0, d}, 64'h8000);
        chk("sat_neg_ovf", {63'd0, o}, 64'd1);
`else
        chk("wrap_neg_ovf", {63'd0, o}, 64'd0);
`endif

        // Backpressure: hold for 5 cycles while the next frame is already offered
        send_frame(300, -200, 500, 1000, 0);
        fork
            recv_check(5, d, o);
            send_frame(100, 200, 300, 400, 0);
        join
        recv_check(0, d, o);
        chk("after_stall_frame", {48'd0, d}, 64'd8);

        // Reset while holding a result clears outputs immediately
        send_frame(128, 128, 128, 128, 0);
        chk("hold_before_reset", {63'd0, out_tvalid}, 64'd1);
        void'(exp_q.pop_front());
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_tvalid", {63'd0, out_tvalid}, 64'd0);
        chk("async_rst_out_tdata", {48'd0, out_tdata}, 64'd0);
        chk("async_rst_prod_tready", {63'd0, prod_tready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-frame discards the partial sum
        send_prod(24'sd1000, 0);
        send_prod(24'sd1000, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(256, 256, 0, 0, 0);
        recv_check(0, d, o);
        chk("mid_frame_reset", {48'd0, d}, 64'd4);

        // Random back-to-back frames with gaps and random backpressure
        mon_en = 1'b1;
        fork
            begin
                for (int f = 0; f < 24; f++) begin
                    mode = $urandom_range(0, 2);
                    for (int k = 0; k < 4; k++) begin
                        if (mode == 0)      r[k] = PROD_W'($urandom);
                        else if (mode == 1) r[k] = PROD_W'(int'($urandom_range(0, 600)) - 300);
                        else                r[k] = ($urandom_range(0, 1) == 1) ? 24'sh7FFFFF : 24'sh800000;
                    end
                    send_frame(int'(r[0]), int'(r[1]), int'(r[2]), int'(r[3]), 2);
                end
            end
            begin
                for (int f = 0; f < 24; f++) begin
                    recv_check($urandom_range(0, 3), d, o);
                end
            end
        join
        mon_en = 1'b0;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
